// File: rtl/spart_receiver_if.sv
// SPART receive-side bus bundle: oversample tick, serial line, bus decode and receiver status.
// Latency: none; these are wires only.
// Backpressure: none; the processor bus polls rda and clears it with a read strobe.
interface spart_receiver_if;
    // Inputs to the receiver
    logic       enable;       // oversample tick from the baud generator
    logic       rxd;          // asynchronous serial line, idles high
    logic       iocs;         // SPART chip select
    logic       iorw;         // 1 = read, 0 = write
    logic [1:0] ioaddr;       // register address, 2'b00 = data register

    // Receiver status and data
    logic [7:0] rx_data;      // last accepted byte
    logic       rda;          // receive data available
    logic       framing_err;  // last frame had a low stop bit
    logic       overrun;      // unread byte was overwritten

    // Bus / baud-generator side: drives the line, tick and decode
    modport master (
        output enable, rxd, iocs, iorw, ioaddr,
        input  rx_data, rda, framing_err, overrun
    );

    // Receiver side
    modport slave (
        input  enable, rxd, iocs, iorw, ioaddr,
        output rx_data, rda, framing_err, overrun
    );
endinterface

// File: rtl/spart_receiver.sv
// SPART receiver: recovers 8N1 frames from rxd using an oversampling tick and holds the byte for the bus.
// Latency: status and data update on the stop-bit-centre tick; rxd is seen 2 clk late through the synchroniser.
// Backpressure: none; an unread byte is overwritten and overrun is raised, and a read clears rda/overrun next edge.
module spart_receiver #(
    parameter int OVERSAMPLE = 16   // enable ticks per bit period, even and >= 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    spart_receiver_if.slave    bus
);

    localparam int CW = $clog2(OVERSAMPLE);

    // Tick counts at which the start bit is re-checked and at which data/stop bits are sampled
    localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_samp_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_sh;

    logic            r_sync1;
    logic            r_sync2;

    logic [7:0]      r_rx_data;
    logic            r_rda;
    logic            r_framing_err;
    logic            r_overrun;

    logic            w_rxd_s;
    logic            w_rd_strobe;

    assign w_rxd_s     = r_sync2;
    assign w_rd_strobe = bus.iocs & bus.iorw & (bus.ioaddr == 2'b00);

    assign bus.rx_data     = r_rx_data;
    assign bus.rda         = r_rda;
    assign bus.framing_err = r_framing_err;
    assign bus.overrun     = r_overrun;

    // Two-flop synchroniser for the asynchronous line; resets to the idle (high) level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM with counters, shift register and registered status/data outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_samp_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_sh          <= '0;
            r_rx_data     <= '0;
            r_rda         <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // A read of the data register acknowledges the byte; a byte accepted
            // on the same edge is written below and takes priority for rda.
            if (w_rd_strobe) begin
                r_rda     <= 1'b0;
                r_overrun <= 1'b0;
            end

            // All frame timing advances only on oversample ticks
            if (bus.enable) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_rxd_s) begin
                            r_state    <= S_START;
                            r_samp_cnt <= '0;
                        end
                    end

                    S_START: begin
                        if (r_samp_cnt == C_HALF) begin
                            if (!w_rxd_s) begin
                                r_state    <= S_DATA;
                                r_samp_cnt <= '0;
                                r_bit_cnt  <= '0;
                            end else begin
                                // Line went back high before mid-bit: treat as noise
                                r_state    <= S_IDLE;
                                r_samp_cnt <= '0;
                            end
                        end else begin
                            r_samp_cnt <= r_samp_cnt + CW'(1);
                        end
                    end

                    S_DATA: begin
                        if (r_samp_cnt == C_LAST) begin
                            // LSB arrives first, so shift in from the top
                            r_sh       <= {w_rxd_s, r_sh[7:1]};
                            r_samp_cnt <= '0;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_samp_cnt <= r_samp_cnt + CW'(1);
                        end
                    end

                    S_STOP: begin
                        if (r_samp_cnt == C_LAST) begin
                            // Back to IDLE at the stop-bit centre so a following start edge is caught
                            r_state    <= S_IDLE;
                            r_samp_cnt <= '0;
                            if (w_rxd_s) begin
                                r_rx_data     <= r_sh;
                                r_rda         <= 1'b1;
                                r_framing_err <= 1'b0;
                                r_overrun     <= r_rda & ~w_rd_strobe;
                            end else begin
                                // Bad stop bit: drop the byte, keep the previous one visible
                                r_framing_err <= 1'b1;
                            end
                        end else begin
                            r_samp_cnt <= r_samp_cnt + CW'(1);
                        end
                    end

                    default: begin
                        r_state    <= S_IDLE;
                        r_samp_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_receiver.sv
// Self-checking bench for spart_receiver: directed frames plus randomized traffic against a sample-instant model.
// Latency: model predicts every output every clk; outputs are compared on the falling edge.
// Backpressure: reads are driven by the bench, directed and random.
module tb_spart_receiver;

    localparam int OVS = 16;
    localparam int H   = OVS / 2;

    logic clk = 1'b0;
    logic rst;

    spart_receiver_if bus_if();

    spart_receiver #(.OVERSAMPLE(OVS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- enable tick generator ----------------
    bit en_on     = 1'b1;
    int en_period = 1;
    int en_cnt    = 0;

    always @(negedge clk) begin
        if (!en_on) begin
            bus_if.enable = 1'b0;
        end else if (en_cnt >= en_period - 1) begin
            bus_if.enable = 1'b1;
            en_cnt = 0;
        end else begin
            bus_if.enable = 1'b0;
            en_cnt++;
        end
    end

    // ---------------- random bus activity ----------------
    bit rnd_bus = 1'b0;

    always @(negedge clk) begin
        if (rnd_bus) begin
            bus_if.iocs   = ($urandom_range(0, 3) == 0);
            bus_if.iorw   = $urandom_range(0, 1);
            bus_if.ioaddr = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        end
    end

    // ---------------- behavioural model ----------------
    // The line as seen at every enable tick is recorded; a frame that starts at
    // tick t0 is decided entirely from the samples at t0+H and t0+H+OVS*k.
    logic [7:0] m_data;
    logic       m_rda, m_fe, m_ov;
    logic       m_s1, m_s2;
    bit         m_busy;
    int         m_t0;
    logic       tick_lv[$];

    always @(posedge clk) begin : model
        logic       rs, rd, old_rda;
        int         n, d;
        logic [7:0] b;
        if (rst) begin
            m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
            m_s1 = 1'b1; m_s2 = 1'b1; m_busy = 1'b0;
        end else begin
            rs   = m_s2;                 // line level 2 clk ago
            m_s2 = m_s1;
            m_s1 = bus_if.rxd;
            rd   = bus_if.iocs && bus_if.iorw && (bus_if.ioaddr == 2'b00);
            old_rda = m_rda;
            if (rd) begin
                m_rda = 1'b0;
                m_ov  = 1'b0;
            end
            if (bus_if.enable === 1'b1) begin
                tick_lv.push_back(rs);
                n = tick_lv.size() - 1;
                if (!m_busy) begin
                    if (!rs) begin
                        m_busy = 1'b1;
                        m_t0   = n;
                    end
                end else begin
                    d = n - m_t0;
                    if (d == H && rs) begin
                        m_busy = 1'b0;
                    end else if (d == H + OVS * 9) begin
                        for (int k = 0; k < 8; k++) b[k] = tick_lv[m_t0 + H + OVS * (k + 1)];
                        m_busy = 1'b0;
                        if (rs) begin
                            m_data = b;
                            m_rda  = 1'b1;
                            m_fe   = 1'b0;
                            m_ov   = old_rda & ~rd;
                        end else begin
                            m_fe = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            check("rx_data",     bus_if.rx_data,     m_data);
            check("rda",         bus_if.rda,         m_rda);
            check("framing_err", bus_if.framing_err, m_fe);
            check("overrun",     bus_if.overrun,     m_ov);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame; optional one-clk read pulse and two-clk reset at given clk offsets
    task automatic send_frame(input logic [7:0] b, input logic stopb, input int rd_at, input int rst_at);
        int bt;
        logic [9:0] bits;
        bt   = OVS * en_period;
        bits = {stopb, b, 1'b0};
        for (int i = 0; i < 10 * bt; i++) begin
            @(negedge clk);
            bus_if.rxd = bits[i / bt];
            if (rd_at >= 0) begin
                bus_if.iocs   = (i == rd_at);
                bus_if.iorw   = 1'b1;
                bus_if.ioaddr = 2'b00;
            end
            if (rst_at >= 0) rst = (i >= rst_at) && (i < rst_at + 2);
        end
        if (rd_at >= 0) bus_if.iocs = 1'b0;
    endtask

    task automatic do_read();
        @(negedge clk);
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b1; bus_if.ioaddr = 2'b00;
        @(negedge clk);
        bus_if.iocs = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        bus_if.rxd = 1'b1; bus_if.iocs = 1'b0; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b00;
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        check("reset_rx_data", bus_if.rx_data, 8'h00);
        check("reset_rda",     bus_if.rda,     1'b0);
        check("reset_fe",      bus_if.framing_err, 1'b0);
        check("reset_ov",      bus_if.overrun, 1'b0);
        rst = 1'b0;
        idle(5);

        // Glitch: 4 clk low is rejected at the mid-bit check
        @(negedge clk); bus_if.rxd = 1'b0;
        idle(4);
        bus_if.rxd = 1'b1;
        idle(40);
        check("glitch_rda",  bus_if.rda,     1'b0);
        check("glitch_data", bus_if.rx_data, 8'h00);

        // Single good frame
        send_frame(8'hA5, 1'b1, -1, -1);
        check("a5_data",  bus_if.rx_data, 8'hA5);
        check("a5_rda",   bus_if.rda,     1'b1);
        check("a5_fe",    bus_if.framing_err, 1'b0);
        check("model_a5", m_data,         8'hA5);
        do_read();
        check("read_rda", bus_if.rda, 1'b0);

        // Framing error then recovery
        send_frame(8'h3C, 1'b0, -1, -1);
        check("fe_set",  bus_if.framing_err, 1'b1);
        check("fe_rda",  bus_if.rda,         1'b0);
        check("fe_data", bus_if.rx_data,     8'hA5);
        bus_if.rxd = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1, -1, -1);
        check("fe_clear",  bus_if.framing_err, 1'b0);
        check("81_rda",    bus_if.rda,         1'b1);
        check("81_data",   bus_if.rx_data,     8'h81);
        do_read();

        // Overrun: two back-to-back frames, no read in between
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        check("ov_data", bus_if.rx_data, 8'h22);
        check("ov_rda",  bus_if.rda,     1'b1);
        check("ov_set",  bus_if.overrun, 1'b1);
        check("model_ov", m_ov,          1'b1);
        do_read();
        check("ov_rd_rda", bus_if.rda,     1'b0);
        check("ov_rd_ov",  bus_if.overrun, 1'b0);

        // Read collision on the stop-sample edge (clk offset 154 with a tick every clk)
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h5A, 1'b1, 154, -1);
        check("col_rda",  bus_if.rda,     1'b1);
        check("col_ov",   bus_if.overrun, 1'b0);
        check("col_data", bus_if.rx_data, 8'h5A);
        do_read();

        // Reset during data bit 4 abandons the frame
        send_frame(8'hFF, 1'b1, -1, OVS * 5 + 8);
        check("rst_data", bus_if.rx_data, 8'h00);
        check("rst_rda",  bus_if.rda,     1'b0);
        send_frame(8'h0F, 1'b1, -1, -1);
        check("0f_data", bus_if.rx_data, 8'h0F);
        check("0f_rda",  bus_if.rda,     1'b1);

        // Randomized traffic: varying tick rate, bad stop bits, glitches, stalls, random bus cycles
        rnd_bus = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int act;
            en_period = $urandom_range(1, 3);
            act = $urandom_range(0, 9);
            if (act < 6) begin
                send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0), -1, -1);
                bus_if.rxd = 1'b1;
                idle($urandom_range(0, 20));
            end else if (act < 8) begin
                @(negedge clk); bus_if.rxd = 1'b0;
                idle($urandom_range(1, H * en_period + 4));
                bus_if.rxd = 1'b1;
                idle($urandom_range(10, 60));
            end else begin
                en_on = 1'b0;
                for (int j = 0; j < 100; j++) begin
                    @(negedge clk);
                    bus_if.rxd = $urandom_range(0, 1);
                end
                bus_if.rxd = 1'b1;
                en_on = 1'b1;
                idle(OVS * en_period * 11);
            end
        end
        rnd_bus = 1'b0;
        @(negedge clk);
        bus_if.iocs = 1'b0;
        bus_if.rxd  = 1'b1;
        idle(OVS * 3 * 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
